// File: rtl/usbh_report_scheduler.sv
// usbh_report_scheduler
// Shares one HID report decoder between two USB host ports. The latest
// report from each port is held in a slot and re-presented to the decoder
// round-robin, so decoder-side autofire phases keep advancing even when a
// port sends no new reports. The decoder's 8-bit button word is captured
// into a per-player register; a port that stays silent for c_timeout_ms is
// declared disconnected and its buttons are cleared.
//
// Ports:
//   i_clk, i_rst              clock (USB core / decoder clock), async active-high reset
//   i_report0/_valid          HID report and one-cycle strobe from port 0
//   i_report1/_valid          HID report and one-cycle strobe from port 1
//   o_dec_report/_valid       report and strobe driven to the decoder
//   i_dec_btn                 decoder button output
//   o_btn0, o_btn1            per-player NES buttons
//   o_btn_strobe[N]           one-cycle pulse whenever o_btnN is written
//   o_connected[N]            port N is live
module usbh_report_scheduler #(
  parameter int c_clk_hz     = 6000000,
  parameter int c_timeout_ms = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_report0,
  input  logic        i_report0_valid,
  input  logic [63:0] i_report1,
  input  logic        i_report1_valid,
  output logic [63:0] o_dec_report,
  output logic        o_dec_report_valid,
  input  logic [7:0]  i_dec_btn,
  output logic [7:0]  o_btn0,
  output logic [7:0]  o_btn1,
  output logic [1:0]  o_btn_strobe,
  output logic [1:0]  o_connected
);

  localparam int c_term  = c_clk_hz / 1000 * c_timeout_ms;
  localparam int c_cnt_w = $clog2(c_term + 1);
  localparam logic [c_cnt_w-1:0] c_term_v = c_cnt_w'(c_term);

  typedef enum logic [2:0] {IDLE, SETUP, FIRE, WAIT, CAPTURE} state_t;

  state_t             state_q, state_d;
  logic [63:0]        rpt_in [2];
  logic [1:0]         rpt_vld;
  logic [63:0]        slot_q [2];
  logic [63:0]        slot_d [2];
  logic [c_cnt_w-1:0] cnt_q [2];
  logic [c_cnt_w-1:0] cnt_d [2];
  logic [7:0]         btn_q [2];
  logic [7:0]         btn_d [2];
  logic [1:0]         live_q, live_d, tmo;
  logic [1:0]         strobe_q, strobe_d;
  logic               ptr_q, ptr_d;
  logic               sel_q, sel_d, sel_pick;
  logic               abort_q, abort_d;
  logic               cap_accept;
  logic [63:0]        dec_report_q, dec_report_d;

  assign rpt_in[0] = i_report0;
  assign rpt_in[1] = i_report1;
  assign rpt_vld   = {i_report1_valid, i_report0_valid};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // A report arriving on the terminal cycle keeps the port alive.
      assign tmo[gi]    = live_q[gi] && (cnt_q[gi] == c_term_v) && !rpt_vld[gi];
      assign live_d[gi] = rpt_vld[gi] || (live_q[gi] && !tmo[gi]);
      assign slot_d[gi] = rpt_vld[gi] ? rpt_in[gi] : slot_q[gi];
      assign cnt_d[gi]  = (rpt_vld[gi] || tmo[gi]) ? '0 :
                          (live_q[gi] ? cnt_q[gi] + 1'b1 : cnt_q[gi]);
      // A capture for a port that times out in the same cycle is already
      // excluded from cap_accept, so the clear always wins.
      assign strobe_d[gi] = tmo[gi] || (cap_accept && (sel_q == 1'(gi)));
      assign btn_d[gi]    = tmo[gi] ? '0 :
                            ((cap_accept && (sel_q == 1'(gi))) ? i_dec_btn : btn_q[gi]);
    end
  endgenerate

  // Prefer the port the pointer names; fall back to the other one.
  assign sel_pick = live_q[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    abort_d      = abort_q;
    dec_report_d = dec_report_q;
    cap_accept   = 1'b0;
    case (state_q)
      IDLE: begin
        // Looking at live_d lets the first service start the cycle the
        // slot becomes live.
        if (live_d != 2'b00) state_d = SETUP;
      end
      SETUP: begin
        sel_d        = sel_pick;
        dec_report_d = slot_q[sel_pick];
        abort_d      = tmo[sel_pick];
        state_d      = FIRE;
      end
      FIRE: begin
        abort_d = abort_q || tmo[sel_q];
        state_d = WAIT;
      end
      WAIT: begin
        abort_d = abort_q || tmo[sel_q];
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Any timeout of the selected port during the service voids it.
        cap_accept = !abort_q && !tmo[sel_q];
        ptr_d      = ~sel_q;
        state_d    = (live_d != 2'b00) ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      sel_q        <= 1'b0;
      abort_q      <= 1'b0;
      live_q       <= '0;
      strobe_q     <= '0;
      dec_report_q <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= '0;
        cnt_q[i]  <= '0;
        btn_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      abort_q      <= abort_d;
      live_q       <= live_d;
      strobe_q     <= strobe_d;
      dec_report_q <= dec_report_d;
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= slot_d[i];
        cnt_q[i]  <= cnt_d[i];
        btn_q[i]  <= btn_d[i];
      end
    end
  end

  assign o_dec_report       = dec_report_q;
  assign o_dec_report_valid = (state_q == FIRE);
  assign o_btn0             = btn_q[0];
  assign o_btn1             = btn_q[1];
  assign o_btn_strobe       = strobe_q;
  assign o_connected        = live_q;

endmodule

// File: tb/tb_usbh_report_scheduler.sv
// Testbench for usbh_report_scheduler. The bench stands in for the decoder:
// it drives a known function of the serviced report onto i_dec_btn only in
// the two cycles before capture and random noise otherwise. A reference
// model describes liveness by time since the last report and services as
// 4-cycle slots; expected decoder strobes and button strobes are queued and
// a negedge monitor matches them against the DUT.
module tb_usbh_report_scheduler;
  localparam int T    = 60;     // 6000 Hz, 10 ms
  localparam int NCYC = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] report0 = '0, report1 = '0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [63:0] dec_report;
  logic        dec_valid;
  logic [7:0]  dec_btn = '0;
  logic [7:0]  btn0, btn1;
  logic [1:0]  strobe, conn;

  always #5 clk = ~clk;

  usbh_report_scheduler #(.c_clk_hz(6000), .c_timeout_ms(10)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_report0(report0), .i_report0_valid(v0),
    .i_report1(report1), .i_report1_valid(v1),
    .o_dec_report(dec_report), .o_dec_report_valid(dec_valid),
    .i_dec_btn(dec_btn),
    .o_btn0(btn0), .o_btn1(btn1),
    .o_btn_strobe(strobe), .o_connected(conn)
  );

  typedef struct { int cyc; logic [63:0] rep; } fire_t;
  typedef struct { int cyc; logic [7:0]  btn; } stb_t;

  int    checks = 0, failures = 0, cyc = 0, fire_cnt = 0;
  fire_t fq[$];
  stb_t  sq0[$], sq1[$];
  logic [1:0] exp_conn = '0;

  // Reference model state
  logic [1:0]  live_hist [NCYC];
  int          last_rx [2];
  logic [63:0] m_slot [2];
  bit          ptr, cur_active, cur_sel;
  int          next_free, cur_s;
  logic [63:0] cur_rep;

  function automatic logic [7:0] dec_f(input logic [63:0] r);
    return r[7:0] ^ r[15:8] ^ r[63:56] ^ 8'h5A;
  endfunction

  // Live in cycle k iff the last report arrived 1..T+1 cycles earlier.
  function automatic bit live_of(input int k, input int n);
    return (k > last_rx[n]) && (k - last_rx[n] <= T + 1);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCYC; i++) live_hist[i] = '0;
    for (int n = 0; n < 2; n++) begin last_rx[n] = -1000000; m_slot[n] = '0; end
    ptr = 0; cur_active = 0; cur_sel = 0; next_free = 0; cur_s = 0; cur_rep = '0;
    fq.delete(); sq0.delete(); sq1.delete();
    exp_conn = '0;
  endtask

  task automatic push_stb(input bit n, input int k, input logic [7:0] b);
    stb_t e;
    e.cyc = k; e.btn = b;
    if (n == 0) sq0.push_back(e); else sq1.push_back(e);
  endtask

  // One clock cycle: advance the model to cycle k, then drive inputs for k.
  task automatic step(input bit a0, input logic [63:0] ra0, input bit a1, input logic [63:0] ra1);
    int k; logic [1:0] lk; bit ok; fire_t f;
    @(posedge clk); cyc++; #1;
    k = cyc;
    lk = {live_of(k, 1), live_of(k, 0)};
    live_hist[k] = lk;
    exp_conn = lk;
    if (cur_active && (k == cur_s + 2 || k == cur_s + 3)) dec_btn = dec_f(cur_rep);
    else dec_btn = 8'($urandom);
    if (cur_active && k == cur_s + 4) begin
      ok = 1;
      for (int j = 0; j <= 4; j++) if (!live_hist[cur_s + j][cur_sel]) ok = 0;
      if (ok) push_stb(cur_sel, k, dec_f(cur_rep));
      cur_active = 0;
    end
    for (int n = 0; n < 2; n++)
      if (live_hist[k-1][n] && !lk[n]) push_stb(n[0], k, 8'h00);
    if (k >= next_free && lk != 2'b00) begin
      cur_sel = lk[ptr] ? ptr : !ptr;
      cur_s = k; cur_rep = m_slot[cur_sel]; cur_active = 1;
      f.cyc = k + 1; f.rep = cur_rep; fq.push_back(f);
      ptr = !cur_sel; next_free = k + 4;
    end
    if (a0) begin last_rx[0] = k; m_slot[0] = ra0; end
    if (a1) begin last_rx[1] = k; m_slot[1] = ra1; end
    v0 = a0; report0 = ra0;
    v1 = a1; report1 = ra1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, rnd64(), 0, rnd64());
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (dec_valid !== 1'b0 || dec_report !== '0 || btn0 !== '0 || btn1 !== '0 ||
        strobe !== '0 || conn !== '0) begin
      failures++;
      $display("FAIL %s valid=%b report=%h btn0=%h btn1=%h strobe=%b conn=%b required all zero",
               tag, dec_valid, dec_report, btn0, btn1, strobe, conn);
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", tag, cyc, got, req);
    end
  endtask

  task automatic check_stb(input bit n, input bit s, input logic [7:0] b);
    stb_t e; bit have;
    have = (n == 0) ? (sq0.size() != 0) : (sq1.size() != 0);
    e.cyc = 0; e.btn = '0;
    if (have) e = (n == 0) ? sq0[0] : sq1[0];
    if (s) begin
      checks++;
      if (!have) begin
        failures++;
        $display("FAIL strobe%0d_unexpected cyc=%0d got_btn=%h required=no strobe", n, cyc, b);
      end else begin
        if (n == 0) void'(sq0.pop_front()); else void'(sq1.pop_front());
        if (e.cyc != cyc || b !== e.btn) begin
          failures++;
          $display("FAIL strobe%0d cyc=%0d got_btn=%h required_cyc=%0d required_btn=%h",
                   n, cyc, b, e.cyc, e.btn);
        end else $display("strobe%0d cyc=%0d btn=%h", n, cyc, b);
      end
    end else if (have && e.cyc <= cyc) begin
      checks++; failures++;
      $display("FAIL strobe%0d_missing cyc=%0d got=none required_cyc=%0d required_btn=%h",
               n, cyc, e.cyc, e.btn);
      if (n == 0) void'(sq0.pop_front()); else void'(sq1.pop_front());
    end
  endtask

  // Monitor: compares DUT presentations against the scoreboard queues.
  fire_t mon_f;
  always @(negedge clk) begin
    if (!rst) begin
      if (dec_valid) begin
        fire_cnt++;
        checks++;
        if (fq.size() == 0) begin
          failures++;
          $display("FAIL fire_unexpected cyc=%0d got_report=%h required=no strobe", cyc, dec_report);
        end else begin
          mon_f = fq.pop_front();
          if (mon_f.cyc != cyc || dec_report !== mon_f.rep) begin
            failures++;
            $display("FAIL fire cyc=%0d got_report=%h required_cyc=%0d required_report=%h",
                     cyc, dec_report, mon_f.cyc, mon_f.rep);
          end
        end
      end else if (fq.size() != 0 && fq[0].cyc <= cyc) begin
        checks++; failures++;
        $display("FAIL fire_missing cyc=%0d got=none required_cyc=%0d", cyc, fq[0].cyc);
        void'(fq.pop_front());
      end
      check_stb(0, strobe[0], btn0);
      check_stb(1, strobe[1], btn1);
      checks++;
      if (conn !== exp_conn) begin
        failures++;
        $display("FAIL connected cyc=%0d got=%b required=%b", cyc, conn, exp_conn);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rep_a, rd1, rd2, rb;
    int c, p, fires_before;
    bit hit;
    model_reset();
    repeat (3) begin @(posedge clk); cyc++; end
    #1;
    check_zero("reset_init");
    rst = 1'b0;

    // Single port, one report: serviced back-to-back, player 1 untouched.
    rep_a = 64'h0000_40F0_8080_0000;
    step(1, rep_a, 0, rnd64());
    idle(40);
    check_val("single_btn0", 64'(btn0), 64'(dec_f(rep_a)));
    check_val("single_btn1", 64'(btn1), 64'h0);
    check_val("single_conn", 64'(conn), 64'h1);

    // Randomized traffic with varying report density (includes timeouts
    // and slot writes during services).
    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(2))
        0: p = 3;
        1: p = 25;
        default: p = 120;
      endcase
      for (int i = 0; i < 100; i++)
        step($urandom_range(p - 1) == 0, rnd64(), $urandom_range(p - 1) == 0, rnd64());
    end

    // Timeout: port 1 alone; a report on the exact terminal cycle keeps it live.
    idle(100);
    rb = rnd64();
    step(0, rnd64(), 1, rb);
    c = cyc;
    while (cyc + 1 < c + 1 + T) step(0, rnd64(), 0, rnd64());
    step(0, rnd64(), 1, rb ^ 64'hFF);
    idle(20);
    check_val("terminal_keeps_live", 64'(conn), 64'h2);
    check_val("terminal_btn1", 64'(btn1), 64'(dec_f(rb ^ 64'hFF)));
    idle(80);
    check_val("timeout_conn", 64'(conn), 64'h0);
    check_val("timeout_btn1", 64'(btn1), 64'h0);

    // Slot update during FIRE only affects the next service of that port.
    rd1 = rnd64(); rd2 = rnd64();
    step(1, rd1, 0, rnd64());
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (cur_active && cur_sel == 0 && cyc + 1 == cur_s + 1) begin
        step(1, rd2, 0, rnd64());
        hit = 1;
      end else step(0, rnd64(), 0, rnd64());
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL midservice_setup got=no FIRE found required=FIRE within 20 cycles");
    end
    idle(20);
    check_val("midservice_btn0", 64'(btn0), 64'(dec_f(rd2)));

    // Reset in the middle of FIRE, then a long quiet stretch.
    step(1, rnd64(), 1, rnd64());
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step(0, rnd64(), 0, rnd64());
      if (cur_active && cyc == cur_s + 1) hit = 1;
    end
    check_val("fire_before_reset", 64'(dec_valid), 64'(hit));
    rst = 1'b1;
    #1;
    check_zero("reset_mid_fire");
    model_reset();
    repeat (3) begin @(posedge clk); cyc++; end
    #1;
    check_zero("reset_held");
    rst = 1'b0;
    fires_before = fire_cnt;
    idle(1000);
    check_val("quiet_after_reset", 64'(fire_cnt - fires_before), 64'h0);
    check_val("quiet_conn", 64'(conn), 64'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
